redun_mont_mul_iter: RTL and testbench

//  Word-serial (CIOS) Montgomery multiplier / repeated-squaring engine, parametrised in width and word size.

---
 rtl/redun_mont_pkg.sv | 36 +++
 rtl/redun_mont_mul_iter_if.sv | 26 ++
 rtl/redun_mont_word_mac.sv | 23 ++
 rtl/redun_mont_mul_iter.sv | 113 +++++++++++
 tb/tb_redun_mont_mul_iter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the word-serial Montgomery multiplier:
// default modulus, its per-word Montgomery constant, FSM states and a latency helper.
package redun_mont_pkg;

  localparam int MONT_DAT_BITS = 1040;
  localparam int MONT_WRD_BITS = 16;

  // Default odd modulus below 2^(DAT_BITS-2); instances override P for their field.
  localparam logic [MONT_DAT_BITS-1:0] P =
    (MONT_DAT_BITS'(1) << (MONT_DAT_BITS - 3)) - MONT_DAT_BITS'(3);

  // -p^-1 mod 2^64 by Newton iteration; each step doubles the number of correct bits.
  function automatic logic [63:0] mont_nprime(input logic [63:0] p_lo);
    logic [63:0] inv;
    inv = 64'd1;
    for (int k = 0; k < 6; k++) inv = inv * (64'd2 - p_lo * inv);
    return -inv;
  endfunction

  localparam logic [63:0] MONT_NPRIME_WRD = mont_nprime(P[63:0]);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_RED,
    ST_SUB,
    ST_OUT
  } mont_state_t;

  // Cycle in which o_val rises when the job is accepted in cycle 0.
  function automatic longint unsigned mont_lat(input longint unsigned sq_cnt,
                                               input int unsigned num_wrds);
    return sq_cnt * (64'(num_wrds) * 64'd2 + 64'd1) + 64'd1;
  endfunction

endpackage

// File: rtl/redun_mont_mul_iter_if.sv
// Operand/result handshake bundle of the Montgomery multiplier.
interface redun_mont_mul_iter_if #(
  parameter int DAT_BITS = 1040,
  parameter int CNT_BITS = 64
);
  logic                i_val;
  logic                o_rdy;
  logic                i_mode;
  logic [DAT_BITS-1:0] i_dat_a;
  logic [DAT_BITS-1:0] i_dat_b;
  logic [CNT_BITS-1:0] i_sq_cnt;
  logic                o_val;
  logic                i_rdy;
  logic [DAT_BITS-1:0] o_dat;
  logic                o_busy;

  modport master (
    output i_val, i_mode, i_dat_a, i_dat_b, i_sq_cnt, i_rdy,
    input  o_rdy, o_val, o_dat, o_busy
  );

  modport slave (
    input  i_val, i_mode, i_dat_a, i_dat_b, i_sq_cnt, i_rdy,
    output o_rdy, o_val, o_dat, o_busy
  );
endinterface

// File: rtl/redun_mont_word_mac.sv
// Combinational acc + x*y for a full-width x and one word y, optionally shifted
// down by one word; kept separate so the word-by-operand product maps on its own.
module redun_mont_word_mac #(
  parameter int OPD_BITS = 1040,
  parameter int WRD_BITS = 16,
  parameter int ACC_BITS = OPD_BITS + WRD_BITS + 2,
  parameter bit SHIFT    = 1'b0
) (
  input  logic [ACC_BITS-1:0] acc,
  input  logic [OPD_BITS-1:0] x,
  input  logic [WRD_BITS-1:0] y,
  output logic [ACC_BITS-1:0] sum
);
  logic [ACC_BITS-1:0] full;

  assign full = acc + ACC_BITS'(x) * ACC_BITS'(y);

  if (SHIFT) begin : g_shift
    assign sum = full >> WRD_BITS;
  end else begin : g_pass
    assign sum = full;
  end
endmodule

// File: rtl/redun_mont_mul_iter.sv
// Word-serial CIOS Montgomery multiplier: one product a*b*R^-1 mod P (mode 0)
// or T chained Montgomery squarings of a (mode 1), R = 2^DAT_BITS.
module redun_mont_mul_iter #(
  parameter int                  DAT_BITS = 1040,
  parameter int                  WRD_BITS = 16,
  parameter logic [DAT_BITS-1:0] P        = redun_mont_pkg::P,
  parameter logic [WRD_BITS-1:0] NPRIME   = redun_mont_pkg::MONT_NPRIME_WRD[WRD_BITS-1:0],
  parameter int                  CNT_BITS = 64
) (
  input logic                  i_clk,
  input logic                  i_rst,
  redun_mont_mul_iter_if.slave bus
);
  import redun_mont_pkg::*;

  localparam int NUM_WRDS = DAT_BITS / WRD_BITS;
  localparam int ACC_BITS = DAT_BITS + WRD_BITS + 2;
  localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

  mont_state_t         state, state_nxt;
  logic [DAT_BITS-1:0] a_q, b_q, dat_q, red_res;
  logic [ACC_BITS-1:0] t_q, mac_sum, red_sum;
  logic [IDX_BITS-1:0] idx;
  logic [CNT_BITS-1:0] cnt;
  logic [WRD_BITS-1:0] m_wrd;
  logic                last_wrd, last_sq, sq_zero;

  // b_q shifts down one word per reduction, so its low word is always b[i].
  redun_mont_word_mac #(
    .OPD_BITS(DAT_BITS), .WRD_BITS(WRD_BITS), .ACC_BITS(ACC_BITS), .SHIFT(1'b0)
  ) u_mac (
    .acc(t_q), .x(a_q), .y(b_q[WRD_BITS-1:0]), .sum(mac_sum)
  );

  redun_mont_word_mac #(
    .OPD_BITS(DAT_BITS), .WRD_BITS(WRD_BITS), .ACC_BITS(ACC_BITS), .SHIFT(1'b1)
  ) u_red (
    .acc(t_q), .x(P), .y(m_wrd), .sum(red_sum)
  );

  assign m_wrd    = t_q[WRD_BITS-1:0] * NPRIME;
  assign last_wrd = (idx == IDX_BITS'(NUM_WRDS - 1));
  assign last_sq  = (cnt == CNT_BITS'(1));
  assign sq_zero  = bus.i_mode && (bus.i_sq_cnt == '0);
  assign red_res  = DAT_BITS'((t_q >= ACC_BITS'(P)) ? t_q - ACC_BITS'(P) : t_q);

  // NOTE: sequential state is written with <= so every process reads pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case, so no branch can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.i_val) state_nxt = sq_zero ? ST_OUT : ST_MAC;
      ST_MAC:  state_nxt = ST_RED;
      ST_RED:  state_nxt = last_wrd ? ST_SUB : ST_MAC;
      ST_SUB:  state_nxt = last_sq ? ST_OUT : ST_MAC;
      ST_OUT:  if (bus.i_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the wide operand and accumulator registers are reset too, so an aborted
  // job leaves no residue and o_dat reads zero straight out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      t_q   <= '0;
      idx   <= '0;
      cnt   <= '0;
      dat_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.i_val) begin
          a_q <= bus.i_dat_a;
          b_q <= bus.i_mode ? bus.i_dat_a : bus.i_dat_b;
          cnt <= bus.i_mode ? bus.i_sq_cnt : CNT_BITS'(1);
          t_q <= '0;
          idx <= '0;
          if (sq_zero) dat_q <= bus.i_dat_a;
        end
        ST_MAC: t_q <= mac_sum;
        ST_RED: begin
          t_q <= red_sum;
          idx <= idx + 1'b1;
          b_q <= b_q >> WRD_BITS;
        end
        ST_SUB: begin
          cnt <= cnt - 1'b1;
          t_q <= '0;
          idx <= '0;
          if (last_sq) begin
            dat_q <= red_res;
          end else begin
            a_q <= red_res;
            b_q <= red_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rdy  = (state == ST_IDLE);
  assign bus.o_val  = (state == ST_OUT);
  assign bus.o_busy = (state != ST_IDLE);
  assign bus.o_dat  = dat_q;

endmodule

// File: tb/tb_redun_mont_mul_iter.sv
// Bench for redun_mont_mul_iter in a 64-bit / 16-bit-word configuration; expected
// results come from plain modular arithmetic with an explicitly computed R^-1.
module tb_redun_mont_mul_iter;
  localparam int          DAT_BITS = 64;
  localparam int          WRD_BITS = 16;
  localparam int          CNT_BITS = 64;
  localparam int          NUM_WRDS = DAT_BITS / WRD_BITS;
  localparam int          ITER_LAT = 2 * NUM_WRDS + 1;
  localparam logic [63:0] P_TB     = 64'h2F3A_7C19_D4E5_0003;
  // Low word of P is 3; 3 * 0x5555 = 0xFFFF = -1 mod 2^16.
  localparam logic [15:0] NPRIME_TB = 16'h5555;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  redun_mont_mul_iter_if #(.DAT_BITS(DAT_BITS), .CNT_BITS(CNT_BITS)) bus ();

  redun_mont_mul_iter #(
    .DAT_BITS(DAT_BITS), .WRD_BITS(WRD_BITS), .P(P_TB), .NPRIME(NPRIME_TB), .CNT_BITS(CNT_BITS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );

  typedef struct {
    string       name;
    logic        mode;
    logic [63:0] a, b, cnt, exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] rinv;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] pr;
    pr = {64'd0, x} * {64'd0, y};
    return 64'(pr % {64'd0, P_TB});
  endfunction

  function automatic logic [63:0] to_mont(input logic [63:0] x);
    logic [127:0] s;
    s = {x, 64'd0};
    return 64'(s % {64'd0, P_TB});
  endfunction

  function automatic logic [63:0] mont_ref(input logic [63:0] x, input logic [63:0] y);
    return mulmod(mulmod(x, y), rinv);
  endfunction

  function automatic logic [63:0] job_ref(input logic mode, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] cnt);
    logic [63:0] x;
    if (!mode) return mont_ref(a, b);
    x = a;
    for (longint unsigned k = 0; k < cnt; k++) x = mont_ref(x, x);
    return x;
  endfunction

  task automatic add_vec(input string name, input logic mode, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] cnt, input logic [63:0] exp,
                         input int lat, input int hold);
    vec_t v;
    v.name = name; v.mode = mode; v.a = a; v.b = b; v.cnt = cnt;
    v.exp = exp; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  // Junk request that would finish in one cycle if it were ever accepted.
  task automatic drive_noise(input int k);
    bus.i_val    = k[0];
    bus.i_mode   = 1'b1;
    bus.i_sq_cnt = '0;
    bus.i_dat_a  = {$urandom, $urandom};
    bus.i_dat_b  = {$urandom, $urandom};
  endtask

  task automatic run_job(input string name, input logic mode, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] cnt, input logic [63:0] exp,
                         input int lat, input int hold, input bit noise);
    int          cyc;
    bit          stable;
    logic [63:0] held;
    @(negedge i_clk);
    check({name, " o_rdy"}, 64'(bus.o_rdy), 64'd1);
    bus.i_val = 1'b1; bus.i_mode = mode; bus.i_dat_a = a; bus.i_dat_b = b; bus.i_sq_cnt = cnt;
    @(posedge i_clk);
    cyc = 1;
    @(negedge i_clk);
    bus.i_val = 1'b0;
    check({name, " busy"}, 64'(bus.o_busy), 64'd1);
    while (!bus.o_val && cyc < lat + 64) begin
      if (noise) drive_noise(cyc);
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
    end
    bus.i_val = 1'b0;
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " o_dat"}, bus.o_dat, exp);
    stable = 1'b1;
    held   = bus.o_dat;
    for (int k = 0; k < hold; k++) begin
      if (noise) drive_noise(k);
      @(posedge i_clk);
      @(negedge i_clk);
      if (!bus.o_val || bus.o_dat !== held) stable = 1'b0;
    end
    bus.i_val = 1'b0;
    if (hold > 0) check({name, " hold"}, 64'(stable), 64'd1);
    bus.i_rdy = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_rdy = 1'b0;
    check({name, " release busy/val/rdy"}, {61'd0, bus.o_busy, bus.o_val, bus.o_rdy}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] inv2, pw, ra, rb, rc, rexp;
    logic        rm;
    int          rt;

    bus.i_val = 1'b0; bus.i_mode = 1'b0; bus.i_dat_a = '0; bus.i_dat_b = '0;
    bus.i_sq_cnt = '0; bus.i_rdy = 1'b0;

    // R^-1 = (1/2)^64 mod P, with 1/2 = (P+1)/2 because P is odd.
    inv2 = (P_TB + 64'd1) >> 1;
    rinv = 64'd1;
    repeat (64) rinv = mulmod(rinv, inv2);

    pw = 64'd2;
    repeat (10) pw = mulmod(pw, pw);

    add_vec("mul_3x5",     1'b0, to_mont(3), to_mont(5), 64'd5, to_mont(15), ITER_LAT + 1, 0);
    add_vec("sq2_t10",     1'b1, to_mont(2), to_mont(9), 64'd10, to_mont(pw), 10 * ITER_LAT + 1, 0);
    add_vec("sq_t0",       1'b1, 64'h1234, 64'h77, 64'd0, 64'h1234, 1, 0);
    // (P-1)^2 = 1 mod P, so one Montgomery squaring yields R^-1.
    add_vec("sq_pm1_t1",   1'b1, P_TB - 64'd1, 64'd0, 64'd1, rinv, ITER_LAT + 1, 0);
    add_vec("mul_pm1_pm1", 1'b0, P_TB - 64'd1, P_TB - 64'd1, 64'd0, rinv, ITER_LAT + 1, 0);
    add_vec("mul_zero",    1'b0, 64'd0, to_mont(7), 64'd0, 64'd0, ITER_LAT + 1, 0);
    add_vec("mul_one",     1'b0, to_mont(1), 64'h1234, 64'd0, 64'h1234, ITER_LAT + 1, 0);
    add_vec("sq3_t3",      1'b1, to_mont(3), 64'd0, 64'd3, to_mont(6561), 3 * ITER_LAT + 1, 0);

    repeat (3) @(posedge i_clk);
    #1;
    check("reset busy/val/rdy", {61'd0, bus.o_busy, bus.o_val, bus.o_rdy}, 64'd1);
    check("reset o_dat", bus.o_dat, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    foreach (vecs[k])
      run_job(vecs[k].name, vecs[k].mode, vecs[k].a, vecs[k].b, vecs[k].cnt,
              vecs[k].exp, vecs[k].lat, vecs[k].hold, 1'b0);

    // Backpressure at OUT with i_val pulses throughout the job.
    run_job("backpressure", 1'b0, to_mont(11), to_mont(13), 64'd0, to_mont(143),
            ITER_LAT + 1, 20, 1'b1);

    // Reset asserted between edges while a long squaring run sits in MAC.
    @(negedge i_clk);
    bus.i_val = 1'b1; bus.i_mode = 1'b1; bus.i_dat_a = to_mont(2); bus.i_sq_cnt = 64'd100;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_val = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("pre-abort busy", 64'(bus.o_busy), 64'd1);
    i_rst = 1'b1;
    #1;
    check("abort busy/val/rdy", {61'd0, bus.o_busy, bus.o_val, bus.o_rdy}, 64'd1);
    check("abort o_dat", bus.o_dat, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_job("post_abort", 1'b0, to_mont(3), to_mont(5), 64'd0, to_mont(15), ITER_LAT + 1, 0, 1'b0);

    for (int j = 0; j < 200; j++) begin
      ra   = {$urandom, $urandom} % P_TB;
      rb   = {$urandom, $urandom} % P_TB;
      rm   = 1'($urandom_range(0, 1));
      rt   = int'($urandom_range(0, 8));
      rc   = rm ? 64'(rt) : {$urandom, $urandom};
      rexp = job_ref(rm, ra, rb, rc);
      run_job($sformatf("rnd%0d", j), rm, ra, rb, rc, rexp,
              rm ? rt * ITER_LAT + 1 : ITER_LAT + 1,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
